// File: rtl/inst_encoder.sv
// Instruction encoder: turns op/src/arg field sets into 16-bit words and
// streams each word as two bytes (high then low) over a valid/ready port.
module inst_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [2:0]  src,
    input  logic [10:0] arg,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        err,
    input  logic        err_clr,
    output logic [7:0]  word_count
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_enc;
    logic [WORD_W-1:0]   w_base;
    logic                w_illegal;
    logic                w_accept;
    logic                w_hs;
    logic [BYTE_W-1:0]   w_nxt_data;
    logic                w_nxt_valid;
    logic                w_nxt_last;

    assign in_ready = (r_state == S_IDLE) | ((r_state == S_LO) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_hs     = out_valid & out_ready;

    // Field encoder; ALU/memory ops with an out-of-range source encode as zero
    always_comb begin
        w_enc     = '0;
        w_base    = '0;
        w_illegal = 1'b0;
        case (op)
            3'd2:    w_base = 16'h8000;
            3'd3:    w_base = 16'h9000;
            3'd4:    w_base = 16'h8800;
            3'd5:    w_base = 16'h9800;
            default: w_base = '0;
        endcase
        case (op)
            3'd0: w_enc = 16'h0000;
            3'd1: w_enc = 16'h0800;
            3'd2, 3'd3, 3'd4, 3'd5: begin
                if (src > 3'd4) begin
                    w_illegal = 1'b1;
                end else begin
                    w_enc = w_base | {5'b0, src, arg[7:0]};
                end
            end
            3'd6:    w_enc = 16'hC000 | {5'b0, arg};
            default: w_enc = 16'hF000 | {11'b0, arg[1], 3'b0, arg[0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next state and next output-register values
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_data  = out_data;
        w_nxt_valid = out_valid;
        w_nxt_last  = out_last;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nxt_state = S_HI;
                    w_nxt_data  = w_enc[15:8];
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = 1'b0;
                end
            end
            S_HI: begin
                if (w_hs) begin
                    w_nxt_state = S_LO;
                    w_nxt_data  = r_word[7:0];
                    w_nxt_last  = 1'b1;
                end
            end
            S_LO: begin
                if (w_hs) begin
                    if (w_accept) begin
                        w_nxt_state = S_HI;
                        w_nxt_data  = w_enc[15:8];
                        w_nxt_valid = 1'b1;
                        w_nxt_last  = 1'b0;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_valid = 1'b0;
                        w_nxt_last  = 1'b0;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_valid = 1'b0;
                w_nxt_last  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            out_data  <= w_nxt_data;
            out_valid <= w_nxt_valid;
            out_last  <= w_nxt_last;
            if (w_accept) begin
                r_word <= w_enc;
            end
            // Setting an error wins over a simultaneous clear
            if (w_accept && w_illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if ((r_state == S_LO) && w_hs) begin
                word_count <= word_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected bytes are queued when a field
// set is driven and compared as each output byte handshakes.
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [2:0]  src;
    logic [10:0] arg;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        err;
    logic        err_clr;
    logic [7:0]  word_count;

    logic        ready_man;
    logic        rnd_mode;
    logic        rnd_bit;

    logic [8:0]  sb_q[$];
    int          n_checks;
    int          n_pass;
    int          n_bytes;
    int          cyc;
    int          hs_cyc[512];

    assign out_ready = ready_man & (~rnd_mode | rnd_bit);

    inst_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .src        (src),
        .arg        (arg),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .err        (err),
        .err_clr    (err_clr),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial rnd_bit = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] m_op, input logic [2:0] m_src,
                                          input logic [10:0] m_arg);
        logic [15:0] lo;
        lo = (16'(m_src) << 8) | 16'(m_arg[7:0]);
        if ((m_op >= 3'd2) && (m_op <= 3'd5) && (m_src >= 3'd5)) return 16'h0000;
        case (m_op)
            3'd0:    return 16'h0000;
            3'd1:    return 16'h0800;
            3'd2:    return 16'h8000 | lo;
            3'd3:    return 16'h9000 | lo;
            3'd4:    return 16'h8800 | lo;
            3'd5:    return 16'h9800 | lo;
            3'd6:    return 16'hC000 | 16'(m_arg);
            default: return 16'hF000 | (16'(m_arg[1]) << 4) | 16'(m_arg[0]);
        endcase
    endfunction

    // Output monitor: every byte handshake pops one expected {last,data}
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 16'(sb_q.size() != 0), 16'd1);
            if (sb_q.size() != 0) begin
                logic [8:0] exp_b;
                exp_b = sb_q.pop_front();
                check("byte", {7'd0, out_last, out_data}, {7'd0, exp_b});
            end
            hs_cyc[n_bytes % 512] = cyc;
            n_bytes++;
        end
    end

    // Present one field set and hold it until accepted; returns at posedge+1
    task automatic send(input logic [2:0] s_op, input logic [2:0] s_src, input logic [10:0] s_arg);
        logic [15:0] w;
        logic        rdy;
        logic        got;
        w = model(s_op, s_src, s_arg);
        sb_q.push_back({1'b0, w[15:8]});
        sb_q.push_back({1'b1, w[7:0]});
        in_valid = 1'b1;
        op       = s_op;
        src      = s_src;
        arg      = s_arg;
        got      = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) got = 1'b1;
        end
        check("accept", 16'(got), 16'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("drain", 16'(done), 16'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int n0;
        n_checks  = 0;
        n_pass    = 0;
        n_bytes   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        src       = '0;
        arg       = '0;
        err_clr   = 1'b0;
        ready_man = 1'b1;
        rnd_mode  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_err", 16'(err), 16'd0);
        check("rst_word_count", 16'(word_count), 16'd0);
        check("rst_out_last", 16'(out_last), 16'd0);
        check("rst_out_data", 16'(out_data), 16'h00);
        @(posedge clk);
        #1;

        // Basic LOAD word
        send(3'd2, 3'd1, 11'h0AB);
        wait_idle();
        check("basic_wc", 16'(word_count), 16'd1);

        // BRANCH then IF back to back
        do_reset();
        n0 = n_bytes;
        send(3'd6, 3'd3, 11'h7FF);
        send(3'd7, 3'd5, 11'h003);
        wait_idle();
        check("bi_wc", 16'(word_count), 16'd2);
        check("no_bubble", 16'(hs_cyc[(n0 + 3) % 512] - hs_cyc[n0 % 512]), 16'd3);

        // Backpressure holds the high byte
        do_reset();
        ready_man = 1'b0;
        send(3'd4, 3'd4, 11'h012);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_data", 16'(out_data), 16'h8C);
            check("bp_valid", 16'(out_valid), 16'd1);
            check("bp_last", 16'(out_last), 16'd0);
            check("bp_in_ready", 16'(in_ready), 16'd0);
            @(posedge clk);
            #1;
        end
        ready_man = 1'b1;
        wait_idle();
        check("bp_wc", 16'(word_count), 16'd1);

        // Illegal source, set-over-clear, clear alone, ignored src
        do_reset();
        send(3'd5, 3'd6, 11'h3FF);
        @(negedge clk);
        check("ill_err_set", 16'(err), 16'd1);
        @(posedge clk);
        #1;
        wait_idle();
        err_clr = 1'b1;
        send(3'd3, 3'd7, 11'h055);
        err_clr = 1'b0;
        @(negedge clk);
        check("ill_set_wins", 16'(err), 16'd1);
        @(posedge clk);
        #1;
        wait_idle();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("ill_clr", 16'(err), 16'd0);
        @(posedge clk);
        #1;
        send(3'd0, 3'd7, 11'h7FF);
        send(3'd1, 3'd5, 11'h000);
        wait_idle();
        check("ignored_src_err", 16'(err), 16'd0);
        check("ill_wc", 16'(word_count), 16'd4);

        // Reset while the low byte is pending
        do_reset();
        send(3'd2, 3'd0, 11'h011);
        @(posedge clk);
        #1;
        ready_man = 1'b0;
        @(negedge clk);
        check("mid_in_lo", 16'(out_last), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        ready_man = 1'b1;
        @(negedge clk);
        check("mid_out_valid", 16'(out_valid), 16'd0);
        check("mid_wc", 16'(word_count), 16'd0);
        check("mid_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;

        // Random words under random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047)));
        end
        wait_idle();
        rnd_mode = 1'b0;
        check("rnd_wc", 16'(word_count), 16'd20);
        check("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
